// File: rtl/cacheline_adapter_pkg.sv
// Shared widths, FSM state type and address helper for the cacheline adapter.
// Line = 4 beats of 64 bits; line addresses are 32-byte aligned.
package cacheline_adapter_pkg;

   localparam int ADDR_W   = 32;
   localparam int LINE_W   = 256;
   localparam int BEAT_W   = 64;
   localparam int BEATS    = 4;
   localparam int OFFSET_W = 5;
   localparam int CNT_W    = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_DATA,
      S_WR_DATA,
      S_DONE
   } state_e;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Cache-side line port plus banked-memory burst port of the cacheline adapter.
// slave = adapter view; master = environment (cache + memory) view.
interface cacheline_adapter_if;
   import cacheline_adapter_pkg::*;

   logic [ADDR_W-1:0] dfp_addr;
   logic              dfp_read;
   logic              dfp_write;
   logic [LINE_W-1:0] dfp_wdata;
   logic [LINE_W-1:0] dfp_rdata;
   logic              dfp_resp;

   logic [ADDR_W-1:0] bmem_addr;
   logic              bmem_read;
   logic              bmem_write;
   logic [BEAT_W-1:0] bmem_wdata;
   logic              bmem_ready;
   logic [ADDR_W-1:0] bmem_raddr;
   logic [BEAT_W-1:0] bmem_rdata;
   logic              bmem_rvalid;

   modport slave (
      input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
      output dfp_rdata, dfp_resp,
      output bmem_addr, bmem_read, bmem_write, bmem_wdata,
      input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
   );

   modport master (
      output dfp_addr, dfp_read, dfp_write, dfp_wdata,
      input  dfp_rdata, dfp_resp,
      input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
      output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
   );

endinterface

// File: rtl/cacheline_adapter.sv
// Splits 256-bit line reads/writes into 4x64-bit memory bursts and reassembles read beats.
// One line in flight; write beats stall on bmem_ready, read beats filtered by raddr tag.
module cacheline_adapter
   import cacheline_adapter_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   cacheline_adapter_if.slave   bus
);

   state_e             r_state;
   state_e             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [ADDR_W-1:0]  r_addr;
   logic [LINE_W-1:0]  r_wdata;
   logic [LINE_W-1:0]  r_line;

   logic               w_rd;
   logic               w_wr;
   logic               w_resp;
   logic               w_beat_ok;
   logic               w_wr_acc;
   logic               w_capture;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Last beat leaves the data state with r_cnt==3, so the increment wraps to 0 exactly there.
   always_comb begin
      w_next    = r_state;
      w_rd      = 1'b0;
      w_wr      = 1'b0;
      w_resp    = 1'b0;
      w_beat_ok = 1'b0;
      w_wr_acc  = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.dfp_write) begin
               w_capture = 1'b1;
               w_next    = S_WR_DATA;
            end else if (bus.dfp_read) begin
               w_capture = 1'b1;
               w_next    = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            w_rd = 1'b1;
            if (bus.bmem_ready) begin
               w_next = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            w_beat_ok = bus.bmem_rvalid && (bus.bmem_raddr == r_addr);
            if (w_beat_ok && (r_cnt == CNT_W'(BEATS - 1))) begin
               w_next = S_DONE;
            end
         end
         S_WR_DATA: begin
            w_wr     = 1'b1;
            w_wr_acc = bus.bmem_ready;
            if (bus.bmem_ready && (r_cnt == CNT_W'(BEATS - 1))) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_resp = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_line  <= '0;
      end else begin
         if (w_capture) begin
            r_addr <= line_align(bus.dfp_addr);
            r_cnt  <= '0;
            if (bus.dfp_write) begin
               r_wdata <= bus.dfp_wdata;
            end
         end
         if (w_beat_ok) begin
            r_line[int'(r_cnt)*BEAT_W +: BEAT_W] <= bus.bmem_rdata;
            r_cnt                               <= r_cnt + 1'b1;
         end
         if (w_wr_acc) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.bmem_addr  = r_addr;
   assign bus.bmem_read  = w_rd;
   assign bus.bmem_write = w_wr;
   assign bus.bmem_wdata = r_wdata[int'(r_cnt)*BEAT_W +: BEAT_W];
   assign bus.dfp_resp   = w_resp;
   assign bus.dfp_rdata  = r_line;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboarded bench for cacheline_adapter: line reads/writes, stalls, filtering, reset abort.
module tb_cacheline_adapter;

   typedef struct {
      logic         is_rd;
      logic [255:0] line;
   } resp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cacheline_adapter_if bus();

   cacheline_adapter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   resp_t        exp_resp_q[$];
   logic [63:0]  exp_wr_q[$];
   int           n_chk  = 0;
   int           n_fail = 0;
   logic         prev_resp = 1'b0;
   resp_t        mon_r;
   logic [63:0]  mon_b;

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] align(input logic [31:0] a);
      logic [31:0] r;
      r = a;
      r[4:0] = 5'd0;
      return r;
   endfunction

   // Scoreboard side: completions and accepted write beats, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         prev_resp = 1'b0;
      end else begin
         if (bus.dfp_resp) begin
            check("resp_single", prev_resp, 1'b0);
            check("resp_expected", exp_resp_q.size() != 0, 1'b1);
            if (exp_resp_q.size() != 0) begin
               mon_r = exp_resp_q.pop_front();
               if (mon_r.is_rd) check("rd_line", bus.dfp_rdata, mon_r.line);
            end
         end
         if (bus.bmem_write && bus.bmem_ready) begin
            check("wr_beat_expected", exp_wr_q.size() != 0, 1'b1);
            if (exp_wr_q.size() != 0) begin
               mon_b = exp_wr_q.pop_front();
               check("wr_beat", bus.bmem_wdata, mon_b);
            end
         end
         prev_resp = bus.dfp_resp;
      end
   end

   task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                          input int exp_wait, input bit bad);
      int n;
      bus.dfp_addr = addr;
      bus.dfp_read = 1'b1;
      exp_resp_q.push_back('{1'b1, line});
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.bmem_read && n < 10);
      check("rd_req_lat", n, exp_wait);
      check("rd_addr", bus.bmem_addr, align(addr));
      bus.bmem_ready = 1'b1;
      step();
      bus.bmem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (bad && k == 2) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = 32'h0000_9000;
            bus.bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            step();
         end
         bus.bmem_rvalid = 1'b1;
         bus.bmem_raddr  = align(addr);
         bus.bmem_rdata  = line[k*64 +: 64];
         step();
      end
      bus.bmem_rvalid = 1'b0;
      check("rd_resp_lat", bus.dfp_resp, 1'b1);
      bus.dfp_read = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                           input logic [5:0] rdy_pat, input bit also_read, input int exp_wait);
      int n;
      int j;
      int cyc;
      bus.dfp_addr  = addr;
      bus.dfp_write = 1'b1;
      bus.dfp_read  = also_read;
      bus.dfp_wdata = line;
      exp_resp_q.push_back('{1'b0, line});
      for (int k = 0; k < 4; k++) exp_wr_q.push_back(line[k*64 +: 64]);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.bmem_write && n < 10);
      check("wr_req_lat", n, exp_wait);
      j   = 0;
      cyc = 0;
      while (j < 4 && cyc < 40) begin
         check("wr_addr", bus.bmem_addr, align(addr));
         check("wr_hold", bus.bmem_wdata, line[j*64 +: 64]);
         check("wr_no_rd", bus.bmem_read, 1'b0);
         bus.bmem_ready = rdy_pat[cyc % 6];
         step();
         if (bus.bmem_ready) j++;
         cyc++;
      end
      bus.bmem_ready = 1'b0;
      check("wr_beats", j, 4);
      check("wr_resp_lat", bus.dfp_resp, 1'b1);
      check("wr_done_quiet", bus.bmem_write, 1'b0);
      bus.dfp_write = 1'b0;
      bus.dfp_read  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] l1;
      logic [255:0] l2;
      logic [255:0] l3;
      rst             = 1'b1;
      bus.dfp_addr    = '0;
      bus.dfp_read    = 1'b0;
      bus.dfp_write   = 1'b0;
      bus.dfp_wdata   = '0;
      bus.bmem_ready  = 1'b0;
      bus.bmem_raddr  = '0;
      bus.bmem_rdata  = '0;
      bus.bmem_rvalid = 1'b0;
      repeat (3) step();
      check("rst_resp", bus.dfp_resp, 1'b0);
      check("rst_bread", bus.bmem_read, 1'b0);
      check("rst_bwrite", bus.bmem_write, 1'b0);
      check("rst_baddr", bus.bmem_addr, 32'd0);
      check("rst_bwdata", bus.bmem_wdata, 64'd0);
      check("rst_rdata", bus.dfp_rdata, 256'd0);
      rst = 1'b0;
      step();

      // basic read with contiguous beats
      do_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1, 1'b0);
      step();
      check("idle_resp", bus.dfp_resp, 1'b0);

      // write with ready stalls
      do_write(32'h0000_2040, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
               6'b101101, 1'b0, 1);
      step();

      // read with a foreign-tagged beat in the middle
      l1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_read(32'h0000_3018, l1, 1, 1'b1);
      step();

      // read and write together: write takes priority
      l2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_write(32'h0000_7777, l2, 6'b111111, 1'b1, 1);
      step();

      // reset during beat 2 of a read, then stray beats
      bus.dfp_addr = 32'h0000_4000;
      bus.dfp_read = 1'b1;
      step();
      check("abort_rd_req", bus.bmem_read, 1'b1);
      bus.bmem_ready = 1'b1;
      step();
      bus.bmem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.bmem_rvalid = 1'b1;
         bus.bmem_raddr  = 32'h0000_4000;
         bus.bmem_rdata  = {32'h5555_0000, 32'(k)};
         if (k == 2) rst = 1'b1;
         step();
      end
      bus.dfp_read = 1'b0;
      check("abort_resp", bus.dfp_resp, 1'b0);
      check("abort_bread", bus.bmem_read, 1'b0);
      check("abort_baddr", bus.bmem_addr, 32'd0);
      check("abort_rdata", bus.dfp_rdata, 256'd0);
      rst = 1'b0;
      bus.bmem_rdata = 64'h5555_0000_0000_0003;
      repeat (2) step();
      bus.bmem_rvalid = 1'b0;
      repeat (2) step();
      check("abort_idle_resp", bus.dfp_resp, 1'b0);
      check("abort_idle_rdata", bus.dfp_rdata, 256'd0);
      l3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_read(32'h0000_4000, l3, 1, 1'b0);
      step();

      // back-to-back write then read
      do_write(32'h0000_5000, ~l3, 6'b111111, 1'b0, 1);
      do_read(32'h0000_6020, l1 ^ l2, 2, 1'b0);
      step();
      check("b2b_idle_resp", bus.dfp_resp, 1'b0);
      repeat (2) step();

      check("sb_resp_empty", exp_resp_q.size(), 0);
      check("sb_wr_empty", exp_wr_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
